// File: rtl/host_link_framer_if.sv
// Read side of the upstream FIFO-style source and write side of the TX FIFO,
// bundled so the framer and its environment connect through one port.
interface host_link_framer_if;
    logic       in_rden;
    logic       in_rdempty;
    logic [7:0] in_rddata;
    logic       out_wren;
    logic       out_wrfull;
    logic [7:0] out_wrdata;

    // Framer side: pulls bytes upstream, pushes bytes downstream.
    modport master (
        output in_rden,
        input  in_rdempty,
        input  in_rddata,
        output out_wren,
        input  out_wrfull,
        output out_wrdata
    );

    // Environment side: upstream source and TX FIFO.
    modport slave (
        input  in_rden,
        output in_rdempty,
        output in_rddata,
        input  out_wren,
        output out_wrfull,
        input  out_wrdata
    );
endinterface

// File: rtl/host_link_framer.sv
// Host link framer: wraps the arbiter byte stream into 0x7E-delimited frames
// with 0x7D/0x20 byte stuffing and a trailing CRC-8 (poly 0x07, init 0x00).
// Frames close after IDLE_CYC empty fetch cycles or after MAX_LEN payload
// bytes. With EN=0 bytes are forwarded verbatim.
module host_link_framer #(
    parameter int unsigned IDLE_CYC = 16,
    parameter int unsigned MAX_LEN  = 64
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    input  logic                       EN,
    host_link_framer_if.master         bus,
    output logic                       frame_open,
    output logic [7:0]                 crc_o
);

    localparam logic [7:0] FLAG     = 8'h7E;
    localparam logic [7:0] ESC      = 8'h7D;
    localparam logic [7:0] ESC_XOR  = 8'h20;
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYC - 1);
    localparam logic [7:0] LEN_MAX  = 8'(MAX_LEN);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PASS,
        ST_SOF,
        ST_DATA,
        ST_DATA_ESC,
        ST_FETCH,
        ST_CRC,
        ST_CRC_ESC,
        ST_EOF
    } state_t;

    state_t     state;
    logic       alive;      // low for the first cycle after reset so strobes stay 0 in reset
    logic       rd_pend;    // a read was issued last cycle; in_rddata is valid now
    logic [7:0] hold;
    logic [7:0] crc;
    logic [7:0] len;
    logic [7:0] idle_cnt;

    logic [7:0] cur;
    logic       wr_req;
    logic [7:0] wr_byte;
    logic       wr_go;
    logic       rd_go;

    function automatic logic [7:0] crc8_next(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic needs_esc(input logic [7:0] b);
        return (b == FLAG) || (b == ESC);
    endfunction

    // Current payload byte: straight off the bus on its arrival cycle, else from the holding register.
    always_comb begin
        cur = rd_pend ? bus.in_rddata : hold;
    end

    // Per-state write request/byte and read strobe; writes are gated by TX FIFO full.
    always_comb begin
        wr_req  = 1'b0;
        wr_byte = '0;
        case (state)
            ST_PASS:     begin wr_req = 1'b1; wr_byte = cur; end
            ST_SOF:      begin wr_req = 1'b1; wr_byte = FLAG; end
            ST_DATA:     begin wr_req = 1'b1; wr_byte = needs_esc(cur) ? ESC : cur; end
            ST_DATA_ESC: begin wr_req = 1'b1; wr_byte = hold ^ ESC_XOR; end
            ST_CRC:      begin wr_req = 1'b1; wr_byte = needs_esc(crc) ? ESC : crc; end
            ST_CRC_ESC:  begin wr_req = 1'b1; wr_byte = crc ^ ESC_XOR; end
            ST_EOF:      begin wr_req = 1'b1; wr_byte = FLAG; end
            default:     begin wr_req = 1'b0; wr_byte = '0; end
        endcase
        wr_go = wr_req && !bus.out_wrfull;
        rd_go = alive && !rd_pend && !bus.in_rdempty &&
                ((state == ST_IDLE) || ((state == ST_FETCH) && (len != LEN_MAX)));
        bus.out_wren   = wr_go;
        bus.out_wrdata = wr_byte;
        bus.in_rden    = rd_go;
    end

    // Framing state machine with holding register, CRC, length and idle counters.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= ST_IDLE;
            alive      <= 1'b0;
            rd_pend    <= 1'b0;
            hold       <= '0;
            crc        <= '0;
            len        <= '0;
            idle_cnt   <= '0;
            frame_open <= 1'b0;
            crc_o      <= '0;
        end else begin
            alive   <= 1'b1;
            rd_pend <= rd_go;
            if (rd_pend) begin
                hold <= bus.in_rddata;
            end
            case (state)
                ST_IDLE: begin
                    if (rd_go) begin
                        state <= EN ? ST_SOF : ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (wr_go) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SOF: begin
                    if (wr_go) begin
                        frame_open <= 1'b1;
                        crc        <= '0;
                        len        <= '0;
                        idle_cnt   <= '0;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (wr_go) begin
                        crc   <= crc8_next(crc, cur);
                        len   <= len + 8'd1;
                        state <= needs_esc(cur) ? ST_DATA_ESC : ST_FETCH;
                    end
                end
                ST_DATA_ESC: begin
                    if (wr_go) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (len == LEN_MAX) begin
                        idle_cnt <= '0;
                        state    <= ST_CRC;
                    end else if (rd_go) begin
                        idle_cnt <= '0;
                        state    <= ST_DATA;
                    end else if (idle_cnt == IDLE_LAST) begin
                        idle_cnt <= '0;
                        state    <= ST_CRC;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                ST_CRC: begin
                    if (wr_go) begin
                        state <= needs_esc(crc) ? ST_CRC_ESC : ST_EOF;
                    end
                end
                ST_CRC_ESC: begin
                    if (wr_go) begin
                        state <= ST_EOF;
                    end
                end
                ST_EOF: begin
                    if (wr_go) begin
                        crc_o      <= crc;
                        frame_open <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
